// File: rtl/zeroheti_dmem_arbiter.sv
//==============================================================================
// Module      : zeroheti_dmem_arbiter
// Description : Round-robin arbiter sharing the single-port DMEM SRAM between
//               bus requesters, with address decode and error responses.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module zeroheti_dmem_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_5000,
    parameter logic [31:0] ADDR_LAST = 32'h0000_9000,
    parameter int          MEM_AW    = $clog2((ADDR_LAST - ADDR_BASE) / 4)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ-1:0]        we_i,
    input  logic [NUM_REQ-1:0][31:0]  addr_i,
    input  logic [NUM_REQ-1:0][3:0]   be_i,
    input  logic [NUM_REQ-1:0][31:0]  wdata_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_AW-1:0]         mem_addr_o,
    output logic [3:0]                mem_be_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i
);

    localparam int c_PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [c_PW-1:0] r_prio;
    logic            r_rsp_valid;
    logic [c_PW-1:0] r_rsp_id;
    logic            r_rsp_err;
    logic            r_rsp_we;

    logic            w_found;
    logic [c_PW-1:0] w_winner;
    logic [c_PW-1:0] w_prio_next;
    logic [31:0]     w_addr;
    logic            w_in_range;
    logic            w_mem_req;
    logic            w_rsp_live;

    // Scan from the priority pointer upward, wrapping; reset masks every grant.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_i[(int'(r_prio) + i) % NUM_REQ]) begin
                w_found  = 1'b1;
                w_winner = c_PW'((int'(r_prio) + i) % NUM_REQ);
            end
        end
        if (rst_i) begin
            w_found = 1'b0;
        end
    end

    always_comb begin
        gnt_o = '0;
        if (w_found) begin
            gnt_o[w_winner] = 1'b1;
        end
    end

    assign w_prio_next = (w_winner == c_PW'(NUM_REQ - 1)) ? '0 : w_winner + c_PW'(1);

    assign w_addr     = addr_i[w_winner];
    assign w_in_range = (w_addr >= ADDR_BASE) && (w_addr < ADDR_LAST);
    assign w_mem_req  = w_found && w_in_range;

    // ADDR_BASE is word aligned, so the word index needs only the upper bits.
    always_comb begin
        mem_req_o   = w_mem_req;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (w_mem_req) begin
            mem_we_o    = we_i[w_winner];
            mem_addr_o  = w_addr[MEM_AW+1:2] - ADDR_BASE[MEM_AW+1:2];
            mem_be_o    = be_i[w_winner];
            mem_wdata_o = wdata_i[w_winner];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_we    <= 1'b0;
        end else begin
            r_rsp_valid <= w_found;
            r_rsp_id    <= w_winner;
            r_rsp_err   <= !w_in_range;
            r_rsp_we    <= we_i[w_winner];
            if (w_found) begin
                r_prio <= w_prio_next;
            end
        end
    end

    // A response registered just before reset is suppressed while reset is held.
    assign w_rsp_live = r_rsp_valid && !rst_i;

    always_comb begin
        rvalid_o = '0;
        if (w_rsp_live) begin
            rvalid_o[r_rsp_id] = 1'b1;
        end
    end

    assign err_o   = w_rsp_live && r_rsp_err;
    assign rdata_o = (w_rsp_live && !r_rsp_err && !r_rsp_we) ? mem_rdata_i : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_zeroheti_dmem_arbiter.sv
//==============================================================================
// Module      : tb_zeroheti_dmem_arbiter
// Description : Directed self-checking bench for zeroheti_dmem_arbiter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_zeroheti_dmem_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] wdata;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [31:0]      rdata;
    logic             err;
    logic             mem_req;
    logic             mem_we;
    logic [11:0]      mem_addr;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zeroheti_dmem_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .be_i        (be),
        .wdata_i     (wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // One-cycle-latency SRAM model with byte enables
    logic [31:0] mem [0:4095];
    logic [31:0] wtmp;
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                wtmp = mem[mem_addr];
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr] <= wtmp;
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req   = '0;
        we    = '0;
        addr  = '0;
        be    = '0;
        wdata = '0;
    endtask

    task automatic set_req(input int i, input logic w, input logic [31:0] a,
                           input logic [3:0] b, input logic [31:0] d);
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        be[i]    = b;
        wdata[i] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clr();
        set_req(0, 1'b0, 32'h5004, 4'hF, 32'h0);
        set_req(1, 1'b0, 32'h5008, 4'hF, 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            #3;
            n_tests++;
            if (gnt !== 2'b00 || mem_req !== 1'b0 || rvalid !== 2'b00 || err !== 1'b0 || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: gnt=%b mem_req=%b rvalid=%b err=%b rdata=%h, expected all zero",
                         c, gnt, mem_req, rvalid, err, rdata);
            end
        end
        step();
        rst = 1'b0;
        #3;
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_gnt: gnt=%b expected 01", gnt);
        end
        step();
        clr();
        #3;
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_rsp: rvalid=%b err=%b expected 01/0", rvalid, err);
        end
        step();
    endtask

    task automatic test_single_read();
        set_req(0, 1'b1, 32'h5004, 4'hF, 32'hDEAD_BEEF);
        #3;
        n_tests++;
        if (gnt !== 2'b01 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h001 || mem_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_write_issue: gnt=%b req=%b we=%b addr=%h wdata=%h expected 01/1/1/001/deadbeef",
                     gnt, mem_req, mem_we, mem_addr, mem_wdata);
        end
        step();
        clr();
        set_req(1, 1'b0, 32'h5004, 4'hF, 32'h0);
        #3;
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL single_write_rsp: rvalid=%b err=%b rdata=%h expected 01/0/0", rvalid, err, rdata);
        end
        n_tests++;
        if (gnt !== 2'b10 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h001) begin
            n_fail++;
            $display("FAIL single_read_issue: gnt=%b req=%b we=%b addr=%h expected 10/1/0/001",
                     gnt, mem_req, mem_we, mem_addr);
        end
        step();
        clr();
        #3;
        n_tests++;
        if (rvalid !== 2'b10 || err !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_read_rsp: rvalid=%b err=%b rdata=%h expected 10/0/deadbeef", rvalid, err, rdata);
        end
        step();
        #3;
        n_tests++;
        if (rvalid !== 2'b00 || gnt !== 2'b00 || mem_req !== 1'b0 || mem_addr !== 12'h0) begin
            n_fail++;
            $display("FAIL single_idle: rvalid=%b gnt=%b mem_req=%b mem_addr=%h expected all zero",
                     rvalid, gnt, mem_req, mem_addr);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_gnt;
        logic [1:0] prev;
        prev = 2'b00;
        set_req(0, 1'b0, 32'h5004, 4'hF, 32'h0);
        set_req(1, 1'b0, 32'h5004, 4'hF, 32'h0);
        for (int c = 0; c < 6; c++) begin
            exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
            #3;
            n_tests++;
            if (gnt !== exp_gnt || rvalid !== prev) begin
                n_fail++;
                $display("FAIL fair[%0d]: gnt=%b rvalid=%b expected %b/%b", c, gnt, rvalid, exp_gnt, prev);
            end
            if (c > 0) begin
                n_tests++;
                if (rdata !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL fair_data[%0d]: rdata=%h expected deadbeef", c, rdata);
                end
            end
            prev = exp_gnt;
            step();
        end
        clr();
        #3;
        n_tests++;
        if (rvalid !== 2'b10 || rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL fair_last: rvalid=%b rdata=%h expected 10/deadbeef", rvalid, rdata);
        end
        step();
    endtask

    task automatic test_out_of_range();
        logic [31:0] bad [3];
        bad[0] = 32'h0000_9000;
        bad[1] = 32'h0000_4FFC;
        bad[2] = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b0, bad[k], 4'hF, 32'h0);
            #3;
            n_tests++;
            if (gnt !== 2'b01 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL oor_issue[%0d]: gnt=%b mem_req=%b expected 01/0", k, gnt, mem_req);
            end
            step();
            clr();
            #3;
            n_tests++;
            if (rvalid !== 2'b01 || err !== 1'b1 || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL oor_rsp[%0d]: rvalid=%b err=%b rdata=%h expected 01/1/0", k, rvalid, err, rdata);
            end
            step();
        end
    endtask

    task automatic test_edge_index();
        set_req(0, 1'b0, 32'h8FFC, 4'hF, 32'h0);
        #3;
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 12'hFFF) begin
            n_fail++;
            $display("FAIL edge_top: mem_req=%b mem_addr=%h expected 1/fff", mem_req, mem_addr);
        end
        step();
        set_req(0, 1'b0, 32'h5002, 4'b1100, 32'h0);
        #3;
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_top_rsp: rvalid=%b err=%b expected 01/0", rvalid, err);
        end
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 12'h000 || mem_be !== 4'b1100) begin
            n_fail++;
            $display("FAIL edge_base: mem_req=%b mem_addr=%h mem_be=%b expected 1/000/1100", mem_req, mem_addr, mem_be);
        end
        step();
        clr();
        #3;
        n_tests++;
        if (rvalid !== 2'b01 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL edge_base_rsp: rvalid=%b err=%b expected 01/0", rvalid, err);
        end
        step();
    endtask

    task automatic test_reset_midflight();
        set_req(0, 1'b0, 32'h5004, 4'hF, 32'h0);
        #3;
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_gnt: gnt=%b expected 01", gnt);
        end
        step();
        rst = 1'b1;
        clr();
        #3;
        n_tests++;
        if (rvalid !== 2'b00 || err !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_drop: rvalid=%b err=%b rdata=%h expected 00/0/0", rvalid, err, rdata);
        end
        step();
        #3;
        n_tests++;
        if (rvalid !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_drop_later: rvalid=%b expected 00", rvalid);
        end
        rst = 1'b0;
        set_req(0, 1'b0, 32'h5004, 4'hF, 32'h0);
        set_req(1, 1'b0, 32'h5004, 4'hF, 32'h0);
        #1;
        n_tests++;
        if (gnt !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_prio: gnt=%b expected 01", gnt);
        end
        step();
        clr();
        step();
    endtask

    initial begin
        rst = 1'b1;
        clr();
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem_rdata = 32'h0;
        test_reset();
        test_single_read();
        test_fairness();
        test_out_of_range();
        test_edge_index();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
